// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-multiplexed 1001 sequence detector.
package seq_det_pkg;

  localparam int MAX_CH = 16;

  // Matched prefix length of 1001.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Result of one detection step.
  typedef struct packed {
    state_t state;
    logic   hit;
  } step_t;

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Channel-side handshake plus hit/busy reporting for seq_det_scheduler.
// The master is the channel front end; the slave is the scheduler.
interface seq_det_scheduler_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_bit;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH-1:0] chan_clear;
  logic              hit_valid;
  logic [CH_W-1:0]   hit_chan;
  logic              busy;

  modport master (
    output in_valid, in_bit, chan_clear,
    input  in_ready, hit_valid, hit_chan, busy
  );

  modport slave (
    input  in_valid, in_bit, chan_clear,
    output in_ready, hit_valid, hit_chan, busy
  );
endinterface

// File: rtl/seq_det_core.sv
// Combinational 1001 Mealy step, shared by all channels of the scheduler.
// Build option: SEQ_DET_SCHED_OVERLAP_EN selects overlapping detection
// (S3 + 1 restarts at S1); undefined gives non-overlapping (S3 + 1 -> S0).
module seq_det_core
  import seq_det_pkg::*;
(
  input  state_t state_in,
  input  logic   bit_in,
  output state_t state_out,
  output logic   hit
);

  step_t res;

  // Next state and hit for one consumed bit.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
    res = '{state: S0, hit: 1'b0};
    case (state_in)
      S0: res.state = bit_in ? S1 : S0;
      S1: res.state = bit_in ? S1 : S2;
      S2: res.state = bit_in ? S1 : S3;
      S3: begin
        res.hit = bit_in;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
        // The completing 1 is also the first bit of the next match.
        res.state = bit_in ? S1 : S0;
`else
        res.state = S0;
`endif
      end
      default: res.state = S0;
    endcase
  end

  assign state_out = res.state;
  assign hit       = res.hit;

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one 1001 detector step across NUM_CH serial
// channels. Holds per-channel state, the arbiter pointer and output registers.
// Build option: SEQ_DET_SCHED_OVERLAP_EN (consumed inside seq_det_core only).
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                reset,
  seq_det_scheduler_if.slave  bus
);

  localparam int CH_W = $clog2(NUM_CH);

  state_t            state      [NUM_CH];
  state_t            state_next [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_next;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic              grant_any;
  logic [CH_W-1:0]   grant_idx;
  state_t            core_state_in;
  state_t            core_state_out;
  logic              core_bit_in;
  logic              core_hit;
  logic              busy_next;
  logic              hit_valid_q;
  logic [CH_W-1:0]   hit_chan_q;
  logic              busy_q;

  // A clear wins over a grant: cleared channels never compete.
  assign eligible = bus.in_valid & ~bus.chan_clear;

  // Round-robin search from ptr; first eligible channel wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = CH_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign bus.in_ready = grant;

  // The single shared step sees only the granted channel.
  assign core_state_in = state[grant_idx];
  assign core_bit_in   = bus.in_bit[grant_idx];

  seq_det_core u_core (
    .state_in  (core_state_in),
    .bit_in    (core_bit_in),
    .state_out (core_state_out),
    .hit       (core_hit)
  );

  // Per-channel write-back and post-update busy flag.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_next[i] = state[i];
      if (bus.chan_clear[i])  state_next[i] = S0;
      else if (grant[i])      state_next[i] = core_state_out;
      busy_next = busy_next | (state_next[i] != S0);
    end
  end

  // Pointer moves past the granted channel, holds when nothing is granted.
  always_comb begin
    ptr_next = ptr;
    if (grant_any) ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  // State, pointer and output registers; reset also drops a same-cycle hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the state array is a handful of flops, not RAM, so it is reset with everything else.
      for (int i = 0; i < NUM_CH; i++) state[i] <= S0;
      ptr         <= '0;
      hit_valid_q <= 1'b0;
      hit_chan_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NUM_CH; i++) state[i] <= state_next[i];
      ptr         <= ptr_next;
      hit_valid_q <= grant_any & core_hit;
      if (grant_any & core_hit) hit_chan_q <= grant_idx;
      busy_q      <= busy_next;
    end
  end

  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_chan  = hit_chan_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed self-checking bench for seq_det_scheduler with NUM_CH = 4.
// Expected hit counts follow SEQ_DET_SCHED_OVERLAP_EN when it is defined.
module tb_seq_det_scheduler;

  localparam int NUM_CH = 4;

`ifdef SEQ_DET_SCHED_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_det_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  seq_det_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  ready_seen;
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit          s7  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, capture in_ready before the edge, return #1 after it.
  task automatic cycle(input logic [3:0] valid, input logic [3:0] bits, input logic [3:0] clear);
    bus.in_valid   = valid;
    bus.in_bit     = bits;
    bus.chan_clear = clear;
    #1 ready_seen = bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = '0; bus.in_bit = '0; bus.chan_clear = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int idx [4];
    int hits;
    int cnt [4];
    int max_ones;
    int g;

    // Reset values
    do_reset();
    #1;
    check("rst hit_valid", 32'(bus.hit_valid), 32'd0);
    check("rst hit_chan",  32'(bus.hit_chan),  32'd0);
    check("rst busy",      32'(bus.busy),      32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd0);

    // 1) Sole requester channel 0 sends 1001
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0001, {3'b000, pat[k]}, 4'b0000);
      check($sformatf("t1 ready%0d", k), 32'(ready_seen), 32'h1);
      check($sformatf("t1 hit%0d", k), 32'(bus.hit_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    check("t1 hit_chan", 32'(bus.hit_chan), 32'd0);
    check("t1 busy",     32'(bus.busy),     32'(OVERLAP));
    cycle(4'b0000, 4'b0000, 4'b0000);
    check("t1 hit drops", 32'(bus.hit_valid), 32'd0);

    // 2) Channels 1 and 2 compete, each sending 1001
    do_reset();
    idx = '{0, 0, 0, 0};
    for (int c = 0; c < 8; c++) begin
      logic [3:0] v, b;
      g = (c % 2 == 0) ? 1 : 2;
      v = '0; b = '0;
      for (int ch = 1; ch <= 2; ch++) begin
        if (idx[ch] < 4) begin
          v[ch] = 1'b1;
          b[ch] = pat[idx[ch]];
        end
      end
      cycle(v, b, 4'b0000);
      check($sformatf("t2 grant%0d", c), 32'(ready_seen), 32'(1 << g));
      idx[g]++;
      check($sformatf("t2 hit%0d", c), 32'(bus.hit_valid), (c >= 6) ? 32'd1 : 32'd0);
      if (c >= 6) check($sformatf("t2 chan%0d", c), 32'(bus.hit_chan), 32'(g));
    end

    // 3) Stream 1001001 on channel 3
    do_reset();
    hits = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(4'b1000, {s7[k], 3'b000}, 4'b0000);
      check($sformatf("t3 ready%0d", k), 32'(ready_seen), 32'h8);
      if (bus.hit_valid && bus.hit_chan == 2'd3) hits++;
    end
    check("t3 hits", 32'(hits), OVERLAP ? 32'd2 : 32'd1);

    // 4) chan_clear on channel 0 after 100
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'b0001, {3'b000, pat[k]}, 4'b0000);
    cycle(4'b0001, 4'b0001, 4'b0001);
    check("t4 clear ready", 32'(ready_seen),    32'd0);
    check("t4 clear hit",   32'(bus.hit_valid), 32'd0);
    check("t4 clear busy",  32'(bus.busy),      32'd0);
    cycle(4'b0001, 4'b0001, 4'b0000);
    check("t4 single1 ready", 32'(ready_seen),    32'h1);
    check("t4 single1 hit",   32'(bus.hit_valid), 32'd0);
    check("t4 single1 busy",  32'(bus.busy),      32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle(4'b0001, {3'b000, pat[k]}, 4'b0000);
      check($sformatf("t4 full hit%0d", k), 32'(bus.hit_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    check("t4 full chan", 32'(bus.hit_chan), 32'd0);

    // 5) Reset mid-sequence on channel 2, including a completing bit under reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100, {1'b0, pat[k], 2'b00}, 4'b0000);
      check($sformatf("t5 ready%0d", k), 32'(ready_seen), 32'h4);
    end
    reset = 1'b1;
    cycle(4'b0100, 4'b0100, 4'b0000);
    reset = 1'b0;
    check("t5 rst hit",  32'(bus.hit_valid), 32'd0);
    check("t5 rst busy", 32'(bus.busy),      32'd0);
    bus.in_valid = 4'b1111; bus.in_bit = 4'b0000; bus.chan_clear = 4'b0000;
    #1;
    check("t5 ptr0", 32'(bus.in_ready), 32'h1);
    cycle(4'b0100, 4'b0100, 4'b0000);
    check("t5 after1 hit",  32'(bus.hit_valid), 32'd0);
    check("t5 after1 busy", 32'(bus.busy),      32'd1);
    cycle(4'b0100, 4'b0000, 4'b0000);
    cycle(4'b0100, 4'b0000, 4'b0000);
    cycle(4'b0100, 4'b0100, 4'b0000);
    check("t5 S1 hit",  32'(bus.hit_valid), 32'd1);
    check("t5 S1 chan", 32'(bus.hit_chan),  32'd2);

    // 6) All four channels valid for 40 cycles
    do_reset();
    cnt = '{0, 0, 0, 0};
    max_ones = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(4'b1111, 4'b0000, 4'b0000);
      check($sformatf("t6 grant%0d", c), 32'(ready_seen), 32'(1 << (c % 4)));
      if ($countones(ready_seen) > max_ones) max_ones = $countones(ready_seen);
      for (int ch = 0; ch < 4; ch++) cnt[ch] += int'(ready_seen[ch]);
    end
    check("t6 onehot", 32'(max_ones), 32'd1);
    for (int ch = 0; ch < 4; ch++) check($sformatf("t6 count%0d", ch), 32'(cnt[ch]), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Time-multiplexes one shared 1001 Mealy detection step among NUM_CH independent serial bit channels. Each cycle, a round-robin arbiter grants one requesting channel. Its saved detector state is fed with the offered bit through the shared step logic, and the next state is written back. Hits are reported with the originating channel number. The block sits between the serial front-end channels and the event/interrupt logic.

## Interface
- NUM_CH, 4: number of serial channels; legal range 2..16.
- CH_W, $clog2(NUM_CH): localparam, channel index width.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all channel states, the arbiter pointer and the outputs.
- in_valid  input  NUM_CH  per-channel bit offered.
- in_bit  input  NUM_CH  per-channel serial bit.
- in_ready  output  NUM_CH  one-hot grant; a bit is consumed when in_valid[i] & in_ready[i].
- chan_clear  input  NUM_CH  per-channel state clear to S0.
- hit_valid  output  1  registered; a sequence completed on the consumed bit.
- hit_chan  output  CH_W  registered; channel of the hit, valid only with hit_valid.
- busy  output  1  registered; at least one channel state is not S0.

## Operation
- Per-channel state register: 2 bits, encoding S0=00, S1=01, S2=10, S3=11, i.e. the matched prefix length of 1001.
- Step function, with (state, bit) giving next state:
  - S0: 1 gives S1; 0 stays S0.
  - S1: 0 gives S2; 1 stays S1.
  - S2: 0 gives S3; 1 gives S1.
  - S3: 1 gives S0 and hit; 0 gives S0.
- Eligible set: in_valid & ~chan_clear.
- Arbiter:
  - Round-robin search starting at pointer ptr, granting the first eligible channel.
  - in_ready is combinational from in_valid, chan_clear and ptr. At most one bit is set.
  - After a grant to channel k, ptr becomes (k+1) mod NUM_CH.
  - With no grant, ptr holds.
- On a grant to channel k:
  - state[k] is loaded with step(state[k], in_bit[k]).
  - The hit result is registered into hit_valid/hit_chan.
- Non-granted channels hold their state; bits offered but not granted are not consumed. The source must hold its bit until granted.
- chan_clear[i] forces state[i] to S0 at the next edge. Clear beats grant: the channel is not eligible that cycle, and its bit is not consumed.
- hit_valid is deasserted in any cycle without a granted hit.
- busy is the OR over the registered (post-update) state != S0.

## Timing
- Reset values: all states S0, ptr 0, hit_valid 0, hit_chan 0, busy 0.
- in_ready is available in the same cycle as in_valid. There is a valid→ready combinational path and no ready→valid dependency.
- Hit latency: hit_valid is high for exactly 1 cycle, starting the cycle after the edge at which the completing bit was consumed.
- Throughput:
  - One bit per cycle aggregate.
  - A channel that is continuously valid is granted at least once every NUM_CH cycles.
  - A sole requester is granted every cycle.
- Reset asserted mid-sequence discards all partial matches. Any hit for a bit consumed in the same cycle as reset is suppressed.
- State is per-channel. Interleaving bits of different channels never creates or breaks a match.

## Configuration
- SEQ_DET_SCHED_OVERLAP_EN defined: overlapping detection. S3 with bit 1 gives S1 plus a hit, because the trailing 1 starts a new match. Channel stream 1001001 then yields 2 hits.
- Not defined: non-overlapping detection. S3 with bit 1 gives S0 plus a hit. Stream 1001001 yields 1 hit.
- The macro affects only the step function.

## Structure
- Package seq_det_pkg holds:
  - the state typedef and its S0..S3 constants;
  - the step function's hit/next-state struct typedef;
  - the max-channel constant, 16.
- Sub-module seq_det_core: purely combinational step (state_in, bit_in → state_out, hit). It is instantiated once and shared. The macro is applied only inside this module.
- The top level holds the state array, the round-robin arbiter, the write-back logic and the output registers.

## Test plan
- Single channel 0, NUM_CH=4, bits 1,0,0,1 on consecutive cycles → granted every cycle; hit_valid=1 and hit_chan=0 one cycle after the 4th bit; busy returns to 0.
- Channels 1 and 2 both continuously valid, each sending 1001 → grants alternate 1,2,1,2; hits for channels 1 and 2 arrive on consecutive cycles, 1 cycle after each final bit.
- Stream 1001001 on channel 3 → 1 hit without the macro, 2 hits with SEQ_DET_SCHED_OVERLAP_EN.
- Channel 0 sends 100, then chan_clear[0] is asserted with in_valid[0]=1 → in_ready[0]=0 that cycle; a following single 1 produces no hit; a full 1001 afterwards hits.
- Reset pulsed after channel 2 has received 100, followed by 1 → no hit, state is S1, ptr=0.
- All 4 channels continuously valid for 40 cycles → each channel granted exactly 10 times; in_ready is never more than one-hot.
